data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a req/ready handshake.
// A request is captured in IDLE, held for WAIT_CYCLES wait states and answered
// with a one-cycle done strobe carrying rdata/err. Misaligned or out-of-range
// accesses are rejected with err and never touch the memory.
//
// state | meaning
// IDLE  | ready=1, waiting for req
// WAIT  | request captured, counting down wait states
// RESP  | done=1 for one cycle with rdata/err, then back to IDLE
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        armed;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          access_err;
  logic [AW-1:0] mem_idx;
  logic [31:0]   rd_val;

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // armed blocks acceptance on the first edge after reset release, so an edge
  // that coincides with deassertion can never start an access.
  assign accept = ready && req && armed;

  // With no wait states the response is formed on the acceptance edge itself,
  // before the capture registers hold the request, so use the live inputs then.
  assign cur_we    = (state == IDLE) ? we    : we_q;
  assign cur_addr  = (state == IDLE) ? addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? wdata : wdata_q;

  assign access_err = (cur_addr[1:0] != 2'b00) ||
                      ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
  assign mem_idx    = cur_addr[AW+1:2];
  assign rd_val     = (!cur_we && !access_err) ? mem[mem_idx] : 32'd0;

  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // Memory array, not reset; a legal write commits on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !access_err) begin
      mem[mem_idx] <= cur_wdata;
    end
  end

  // Control FSM with capture registers, wait-state down-counter and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      armed   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= access_err;
              rdata <= rd_val;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
            done  <= 1'b1;
            err   <= access_err;
            rdata <= rd_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'd0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses
// WAIT_CYCLES=0. A transaction-level model predicts every output each cycle;
// directed accesses also carry hand-computed literal expectations.
module tb_data_mem_responder;

  logic              clk;
  logic              reset;
  logic [1:0]        req_v, we_v;
  logic [1:0][31:0]  addr_v, wdata_v;
  logic [1:0]        ready_v, done_v, err_v, busy_v;
  logic [1:0][31:0]  rdata_v;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 0;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .ready(ready_v[0]), .done(done_v[0]), .rdata(rdata_v[0]),
    .err(err_v[0]), .busy(busy_v[0]));

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .ready(ready_v[1]), .done(done_v[1]), .rdata(rdata_v[1]),
    .err(err_v[1]), .busy(busy_v[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  int          since_rst = 0;
  bit          pend [2];
  int          acc [2];
  bit          pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  bit          e_done [2];
  bit          e_err [2];
  bit          e_known [2];
  bit          e_ready [2];
  logic [31:0] e_rdata [2];
  logic [31:0] mm [2][64];
  bit          kn [2][64];

  task automatic step(input int i);
    int w;
    w = (i == 0) ? 2 : 0;
    e_done[i] = 0; e_err[i] = 0; e_rdata[i] = 32'd0; e_known[i] = 1;
    if (pend[i] && cyc == acc[i] + w + 1) begin
      pend[i] = 0;  // response cycle ends here; this edge returns to idle only
    end else if (!pend[i] && req_v[i] && since_rst >= 2) begin
      pend[i] = 1; acc[i] = cyc;
      pw[i] = we_v[i]; pa[i] = addr_v[i]; pd[i] = wdata_v[i];
    end
    if (pend[i] && cyc == acc[i] + w) begin
      e_done[i] = 1;
      if (pa[i][1:0] != 2'b00 || pa[i][31:2] >= 30'd64) begin
        e_err[i] = 1;
      end else if (pw[i]) begin
        mm[i][int'(pa[i][31:2])] = pd[i];
        kn[i][int'(pa[i][31:2])] = 1;
      end else begin
        e_rdata[i] = mm[i][int'(pa[i][31:2])];
        e_known[i] = kn[i][int'(pa[i][31:2])];
      end
    end
    e_ready[i] = !pend[i];
  endtask

  // Model advances on every clock edge and is cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      since_rst = 0;
      for (int i = 0; i < 2; i++) begin
        pend[i] = 0; e_done[i] = 0; e_err[i] = 0;
        e_rdata[i] = 32'd0; e_known[i] = 1; e_ready[i] = 1;
      end
    end else begin
      cyc++;
      since_rst++;
      for (int i = 0; i < 2; i++) step(i);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d ready", i), 32'(ready_v[i]), 32'(e_ready[i]));
        chk($sformatf("m%0d busy", i), 32'(busy_v[i]), 32'(!e_ready[i]));
        chk($sformatf("m%0d done", i), 32'(done_v[i]), 32'(e_done[i]));
        chk($sformatf("m%0d err", i), 32'(err_v[i]), 32'(e_err[i]));
        if (e_known[i]) chk($sformatf("m%0d rdata", i), rdata_v[i], e_rdata[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input int i, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] exp_rd, input bit exp_er, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = a; wdata_v[i] = d;
    @(negedge clk);
    // Acceptance edge has passed; disturb the inputs to show they are ignored.
    req_v[i] = 1'b0; we_v[i] = ~w; addr_v[i] = 32'hFFFF_FFFF; wdata_v[i] = $urandom;
    n = 1; seen = 0;
    while (!seen && n <= 20) begin
      if (done_v[i]) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    if (seen) begin
      chk({nm, " rdata"}, rdata_v[i], exp_rd);
      chk({nm, " err"}, 32'(err_v[i]), 32'(exp_er));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d1, d2, ndone;
    logic [31:0] r1, r2;
    req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_on = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset ready", 32'(ready_v[i]), 32'd1);
      chk("reset busy", 32'(busy_v[i]), 32'd0);
      chk("reset done", 32'(done_v[i]), 32'd0);
      chk("reset rdata", rdata_v[i], 32'd0);
    end
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    access(0, 1, 32'h08, 32'hDEADBEEF, 3, 32'd0, 0, "wr08");
    access(0, 0, 32'h08, 32'd0, 3, 32'hDEADBEEF, 0, "rd08");
    access(0, 1, 32'h04, 32'h12345678, 3, 32'd0, 0, "wr04");
    access(0, 1, 32'h06, 32'hCAFEBABE, 3, 32'd0, 1, "wr06 misaligned");
    access(0, 0, 32'h04, 32'd0, 3, 32'h12345678, 0, "rd04 after misaligned");
    access(0, 0, 32'h100, 32'd0, 3, 32'd0, 1, "rd100 out of range");
    access(0, 1, 32'hFC, 32'h600DF00D, 3, 32'd0, 0, "wrFC last word");
    access(0, 0, 32'hFC, 32'd0, 3, 32'h600DF00D, 0, "rdFC last word");
    access(0, 1, 32'h10, 32'hA5A5A5A5, 3, 32'd0, 0, "wr10");
    access(0, 1, 32'h14, 32'h5A5A5A5A, 3, 32'd0, 0, "wr14");

    // Back-to-back reads with req held high; inputs disturbed during the first wait.
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10; wdata_v[0] = 32'd0;
    d1 = -1; d2 = -1; ndone = 0; r1 = 32'd0; r2 = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin we_v[0] = 1'b1; addr_v[0] = 32'h14; wdata_v[0] = 32'h77777777; end
      if (k == 3) we_v[0] = 1'b0;
      if (done_v[0]) begin
        ndone++;
        if (d1 < 0) begin d1 = k; r1 = rdata_v[0]; end
        else if (d2 < 0) begin d2 = k; r2 = rdata_v[0]; end
      end
      if (k inside {1, 2, 3, 5, 6, 7}) chk($sformatf("b2b ready k=%0d", k), 32'(ready_v[0]), 32'd0);
      if (k == 4) chk("b2b ready idle gap", 32'(ready_v[0]), 32'd1);
      if (k == 7) req_v[0] = 1'b0;
    end
    chk("b2b first done cycle", 32'(d1), 32'd3);
    chk("b2b second done cycle", 32'(d2), 32'd7);
    chk("b2b done spacing", 32'(d2 - d1), 32'd4);
    chk("b2b done count", 32'(ndone), 32'd2);
    chk("b2b first rdata", r1, 32'hA5A5A5A5);
    chk("b2b second rdata", r2, 32'h5A5A5A5A);
    access(0, 0, 32'h10, 32'd0, 3, 32'hA5A5A5A5, 0, "rd10 after b2b");

    // Reset while a write is waiting: it must be dropped.
    access(0, 1, 32'h0C, 32'hCAFEF00D, 3, 32'd0, 0, "wr0C");
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h0C; wdata_v[0] = 32'h11111111;
    @(negedge clk);
    req_v[0] = 1'b0;
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid-reset done", 32'(done_v[0]), 32'd0);
      chk("mid-reset ready", 32'(ready_v[0]), 32'd1);
    end
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    access(0, 0, 32'h0C, 32'd0, 3, 32'hCAFEF00D, 0, "rd0C after reset");

    // Zero wait states.
    access(1, 1, 32'h20, 32'h0BADCAFE, 1, 32'd0, 0, "wc0 wr20");
    chk("wc0 busy in resp", 32'(ready_v[1]), 32'd0);
    @(negedge clk);
    chk("wc0 ready after resp", 32'(ready_v[1]), 32'd1);
    access(1, 0, 32'h20, 32'd0, 1, 32'h0BADCAFE, 0, "wc0 rd20");
    access(1, 0, 32'h22, 32'd0, 1, 32'd0, 1, "wc0 misaligned");

    repeat (3) @(negedge clk);
    model_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
